rf_writeback: RTL and testbench

//  Write-side controller for the 32x32 register file. Merges two result producers, the single-cycle
//  ALU and the variable-latency load unit, onto the register file's single write port (w_ena/w_addr/w_data).
//  ALU results always win arbitration. Load results are buffered in a small FIFO.
//  An optional scoreboard tracks registers that are waiting on a load.

---
 rtl/rf_wb_pkg.sv | 14 +
 rtl/rf_wb_fifo.sv | 65 ++++++
 rtl/rf_writeback.sv | 92 +++++++++
 tb/tb_rf_writeback.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared widths and load-buffer entry type for the register-file writeback block
package rf_wb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

  typedef struct packed {
    logic                  live;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } lb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - circular load buffer with squash-by-address of queued entries
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  lb_entry_t             push_entry,
  input  logic                  pop,
  output lb_entry_t             head,
  output logic                  empty,
  output logic                  full,
  input  logic                  squash,
  input  logic [DEF_ADDR_W-1:0] squash_addr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  lb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  lb_entry_t        wr_entry;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // An entry pushed in the same cycle as a matching ALU write is already stale.
  always_comb begin
    wr_entry = push_entry;
    if (squash && push_entry.addr == squash_addr) wr_entry.live = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && mem[i].addr == squash_addr) mem[i].live <= 1'b0;
      end
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - ALU/load write-port arbiter; optional busy scoreboard under RF_WB_SCOREBOARD_EN
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LB_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 issue_ld,
  input  logic [ADDR_W-1:0]    issue_addr,
  output logic                 rf_w_ena,
  output logic [ADDR_W-1:0]    rf_w_addr,
  output logic [DATA_W-1:0]    rf_w_data,
  output logic [2**ADDR_W-1:0] busy_vec,
  output logic                 lb_empty
);

  logic      lb_full;
  logic      lb_push;
  logic      lb_pop;
  logic      alu_wr;
  lb_entry_t push_entry;
  lb_entry_t head;

  assign ld_ready   = !lb_full && rst_n;
  assign lb_push    = ld_valid && ld_ready;
  assign lb_pop     = !alu_valid && !lb_empty;
  assign alu_wr     = alu_valid && (alu_addr != '0);
  assign push_entry = '{live: 1'b1, addr: ld_addr, data: ld_data};

  rf_wb_fifo #(.DEPTH(LB_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (lb_push),
    .push_entry  (push_entry),
    .pop         (lb_pop),
    .head        (head),
    .empty       (lb_empty),
    .full        (lb_full),
    .squash      (alu_wr),
    .squash_addr (alu_addr)
  );

  // Dropped writes (reg 0, dead head, idle) leave addr/data untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_w_ena  <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
    end else if (alu_wr) begin
      rf_w_ena  <= 1'b1;
      rf_w_addr <= alu_addr;
      rf_w_data <= alu_data;
    end else if (lb_pop && head.live && head.addr != '0) begin
      rf_w_ena  <= 1'b1;
      rf_w_addr <= head.addr;
      rf_w_data <= head.data;
    end else begin
      rf_w_ena  <= 1'b0;
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic [2**ADDR_W-1:0] busy_q;

  // The set is written last so a same-cycle re-issue keeps the bit high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      if (lb_pop && head.addr != '0) busy_q[head.addr] <= 1'b0;
      if (issue_ld && issue_addr != '0) busy_q[issue_addr] <= 1'b1;
    end
  end

  assign busy_vec = busy_q;
`else
  logic unused_issue;
  assign unused_issue = ^{issue_ld, issue_addr};
  assign busy_vec     = '0;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - directed table, corner sequences and random model check of rf_writeback
module tb_rf_writeback;

  localparam int AW = 5;
  localparam int DW = 32;
`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SB_ON = 1'b1;
`else
  localparam bit SB_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          issue_ld;
  logic [AW-1:0] issue_addr;
  logic          rf_w_ena;
  logic [AW-1:0] rf_w_addr;
  logic [DW-1:0] rf_w_data;
  logic [31:0]   busy_vec;
  logic          lb_empty;

  always #5 clk = ~clk;

  rf_writeback #(.DATA_W(DW), .ADDR_W(AW), .LB_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .issue_ld   (issue_ld),
    .issue_addr (issue_addr),
    .rf_w_ena   (rf_w_ena),
    .rf_w_addr  (rf_w_addr),
    .rf_w_data  (rf_w_data),
    .busy_vec   (busy_vec),
    .lb_empty   (lb_empty)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid  = 1'b0; alu_addr = '0; alu_data = '0;
    ld_valid   = 1'b0; ld_addr  = '0; ld_data  = '0;
    issue_ld   = 1'b0; issue_addr = '0;
  endtask

  typedef struct {
    bit          av;
    logic [4:0]  aa;
    logic [31:0] ad;
    bit          lv;
    logic [4:0]  la;
    logic [31:0] ldd;
    bit          e_rdy;
    bit          e_ena;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    bit          e_empty;
  } vec_t;

  function automatic vec_t mk(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                              input bit lv, input logic [4:0] la, input logic [31:0] ldd,
                              input bit e_rdy, input bit e_ena, input logic [4:0] e_addr,
                              input logic [31:0] e_data, input bit e_empty);
    mk = '{av, aa, ad, lv, la, ldd, e_rdy, e_ena, e_addr, e_data, e_empty};
  endfunction

  typedef struct {
    bit          live;
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  vec_t        vt[$];
  ent_t        mq[$];
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_busy;
  bit          m_ena;

  initial begin
    // ALU path, reg-0 drop
    vt.push_back(mk(1, 5,  32'hDEADBEEF, 0, 0,  0,     1, 1, 5,  32'hDEADBEEF, 1));
    vt.push_back(mk(1, 0,  32'h12345678, 0, 0,  0,     1, 0, 5,  32'hDEADBEEF, 1));
    // contention: loads queue behind a 3-cycle ALU burst
    vt.push_back(mk(1, 1,  32'h100,      1, 7,  32'h11, 1, 1, 1,  32'h100,      0));
    vt.push_back(mk(1, 2,  32'h200,      1, 8,  32'h22, 1, 1, 2,  32'h200,      0));
    vt.push_back(mk(1, 3,  32'h300,      1, 4,  32'h44, 0, 1, 3,  32'h300,      0));
    vt.push_back(mk(0, 0,  0,            0, 0,  0,     0, 1, 7,  32'h11,       0));
    vt.push_back(mk(0, 0,  0,            0, 0,  0,     1, 1, 8,  32'h22,       1));
    vt.push_back(mk(0, 0,  0,            0, 0,  0,     1, 0, 8,  32'h22,       1));
    // squash of a queued load
    vt.push_back(mk(0, 0,  0,            1, 9,  32'hAA, 1, 0, 8,  32'h22,       0));
    vt.push_back(mk(1, 9,  32'h1,        0, 0,  0,     1, 1, 9,  32'h1,        0));
    vt.push_back(mk(0, 0,  0,            0, 0,  0,     1, 0, 9,  32'h1,        1));
    vt.push_back(mk(0, 0,  0,            0, 0,  0,     1, 0, 9,  32'h1,        1));
    // squash of a load pushed in the same cycle
    vt.push_back(mk(1, 10, 32'h5,        1, 10, 32'h6,  1, 1, 10, 32'h5,        0));
    vt.push_back(mk(0, 0,  0,            0, 0,  0,     1, 0, 10, 32'h5,        1));
    // load to reg 0 is popped silently
    vt.push_back(mk(0, 0,  0,            1, 0,  32'h77, 1, 0, 10, 32'h5,        0));
    vt.push_back(mk(0, 0,  0,            0, 0,  0,     1, 0, 10, 32'h5,        1));
    // no push while full even with a pop that cycle
    vt.push_back(mk(0, 0,  0,            1, 11, 32'hB1, 1, 0, 10, 32'h5,        0));
    vt.push_back(mk(1, 12, 32'hC,        1, 13, 32'hB2, 1, 1, 12, 32'hC,        0));
    vt.push_back(mk(0, 0,  0,            1, 14, 32'hB3, 0, 1, 11, 32'hB1,       0));
    vt.push_back(mk(0, 0,  0,            1, 14, 32'hB3, 1, 1, 13, 32'hB2,       0));
    vt.push_back(mk(0, 0,  0,            0, 0,  0,     1, 1, 14, 32'hB3,       1));
    vt.push_back(mk(0, 0,  0,            0, 0,  0,     1, 0, 14, 32'hB3,       1));

    // reset held two clocks with a load offered
    idle();
    rst_n    = 1'b0;
    ld_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ena",   rf_w_ena, 0);
      chk("rst_busy",  busy_vec, 0);
      chk("rst_empty", lb_empty, 1);
      chk("rst_ready", ld_ready, 0);
    end
    rst_n    = 1'b1;
    ld_valid = 1'b0;
    #1;
    chk("rel_ready", ld_ready, 1);

    foreach (vt[i]) begin
      alu_valid = vt[i].av; alu_addr = vt[i].aa; alu_data = vt[i].ad;
      ld_valid  = vt[i].lv; ld_addr  = vt[i].la; ld_data  = vt[i].ldd;
      #1;
      chk($sformatf("tbl%0d_ready", i), ld_ready, vt[i].e_rdy);
      tick();
      chk($sformatf("tbl%0d_ena", i),   rf_w_ena,  vt[i].e_ena);
      chk($sformatf("tbl%0d_addr", i),  rf_w_addr, vt[i].e_addr);
      chk($sformatf("tbl%0d_data", i),  rf_w_data, vt[i].e_data);
      chk($sformatf("tbl%0d_empty", i), lb_empty,  vt[i].e_empty);
    end
    idle();

    // scoreboard set, clear on emit, and set-wins on a same-cycle re-issue
    issue_ld = 1'b1; issue_addr = 3;
    tick();
    chk("sb_set", busy_vec[3], SB_ON);
    issue_ld = 1'b0;
    ld_valid = 1'b1; ld_addr = 3; ld_data = 32'h33;
    tick();
    ld_valid = 1'b0;
    chk("sb_hold", busy_vec[3], SB_ON);
    chk("sb_nobypass", rf_w_ena, 0);
    tick();
    chk("sb_emit_ena", rf_w_ena, 1);
    chk("sb_emit_addr", rf_w_addr, 3);
    chk("sb_clr", busy_vec[3], 0);
    issue_ld = 1'b1; issue_addr = 3;
    tick();
    issue_ld = 1'b0;
    ld_valid = 1'b1; ld_addr = 3; ld_data = 32'h34;
    tick();
    ld_valid = 1'b0;
    issue_ld = 1'b1; issue_addr = 3;
    tick();
    issue_ld = 1'b0;
    chk("sb_re_ena", rf_w_ena, 1);
    chk("sb_re_data", rf_w_data, 32'h34);
    chk("sb_re_keep", busy_vec[3], SB_ON);

    // reset with a full buffer and busy bits pending
    alu_valid = 1'b1; alu_addr = 20; alu_data = 32'h20;
    ld_valid  = 1'b1; ld_addr  = 21; ld_data  = 32'h21;
    issue_ld  = 1'b1; issue_addr = 21;
    tick();
    ld_addr = 22; ld_data = 32'h22; issue_addr = 22;
    tick();
    idle();
    #1;
    chk("mid_full", ld_ready, 0);
    chk("mid_busy", busy_vec, SB_ON ? 32'h0060_0008 : 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", busy_vec, 0);
    chk("mid_rst_empty", lb_empty, 1);
    chk("mid_rst_addr", rf_w_addr, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid_post%0d_ena", i), rf_w_ena, 0);
      chk($sformatf("mid_post%0d_empty", i), lb_empty, 1);
    end

    // random traffic against a queue model
    mq.delete();
    m_addr = '0; m_data = '0; m_busy = '0;
    for (int c = 0; c < 400; c++) begin
      bit exp_rdy;
      bit accept;
      alu_valid  = ($urandom_range(0, 2) == 0);
      alu_addr   = 5'($urandom_range(0, 7));
      alu_data   = $urandom;
      ld_valid   = ($urandom_range(0, 1) == 1);
      ld_addr    = 5'($urandom_range(0, 7));
      ld_data    = $urandom;
      issue_ld   = ($urandom_range(0, 3) == 0);
      issue_addr = 5'($urandom_range(0, 7));
      #1;
      exp_rdy = (mq.size() < 2);
      chk($sformatf("rnd%0d_ready", c), ld_ready, exp_rdy);
      accept = ld_valid && exp_rdy;
      m_ena  = 1'b0;
      if (alu_valid) begin
        if (alu_addr != 0) begin
          m_ena = 1'b1; m_addr = alu_addr; m_data = alu_data;
        end
      end else if (mq.size() > 0) begin
        ent_t h;
        h = mq.pop_front();
        if (h.live && h.a != 0) begin
          m_ena = 1'b1; m_addr = h.a; m_data = h.d;
        end
        if (h.a != 0) m_busy[h.a] = 1'b0;
      end
      if (accept) mq.push_back('{1'b1, ld_addr, ld_data});
      if (alu_valid && alu_addr != 0) begin
        foreach (mq[k]) if (mq[k].a == alu_addr) mq[k].live = 1'b0;
      end
      if (issue_ld && issue_addr != 0) m_busy[issue_addr] = 1'b1;
      tick();
      chk($sformatf("rnd%0d_ena", c),   rf_w_ena,  m_ena);
      chk($sformatf("rnd%0d_addr", c),  rf_w_addr, m_addr);
      chk($sformatf("rnd%0d_data", c),  rf_w_data, m_data);
      chk($sformatf("rnd%0d_empty", c), lb_empty,  mq.size() == 0);
      chk($sformatf("rnd%0d_busy", c),  busy_vec,  SB_ON ? m_busy : 32'h0);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
